// File: rtl/panel_switch_ctrl.sv
// Front-panel switch register owner: arbitrates keyboard and host switch requests,
// applies toggles directly and runs momentary switches through press/command/hold/release.
//
// state     | meaning
// S_IDLE    | waiting for a pending kb/host entry; grants one and captures it
// S_APPLY   | classify working entry; update toggle bit or start a momentary press
// S_CMD     | cmd_valid_o held with stable cmd_code_o until cmd_ready_i
// S_HOLD    | momentary bit held high while the hold counter runs down
// S_RELEASE | momentary bit cleared, back to idle
module panel_switch_ctrl #(
  parameter int unsigned NUM_SW            = 25,
  parameter int unsigned SWITCHES_ST_COUNT = 18,
  parameter int unsigned AUX1_INDEX        = 23,
  parameter int unsigned AUX2_INDEX        = 24,
  parameter int unsigned HOLD_CYCLES       = 500000,
  parameter int unsigned CNT_W             = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kb_valid_i,
  input  logic [4:0]        kb_index_i,
  input  logic [1:0]        kb_action_i,
  input  logic              host_valid_i,
  input  logic [4:0]        host_index_i,
  input  logic [1:0]        host_action_i,
  output logic              host_ready_o,
  output logic [NUM_SW-1:0] switches_o,
  output logic              cmd_valid_o,
  output logic [5:0]        cmd_code_o,
  input  logic              cmd_ready_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_CMD,
    S_HOLD,
    S_RELEASE
  } state_t;

  localparam logic [1:0] ACT_CLEAR = 2'd0;
  localparam logic [1:0] ACT_UP    = 2'd1;
  localparam logic [1:0] ACT_DOWN  = 2'd2;
  localparam logic [1:0] ACT_MOVE  = 2'd3;

  state_t            state_q;
  logic              kb_pend_q;
  logic [4:0]        kb_idx_q;
  logic [1:0]        kb_act_q;
  logic              host_pend_q;
  logic [4:0]        host_idx_q;
  logic [1:0]        host_act_q;
  logic              last_host_q;
  logic [4:0]        work_idx_q;
  logic [1:0]        work_act_q;
  logic [NUM_SW-1:0] sw_q;
  logic              cmd_valid_q;
  logic [5:0]        cmd_code_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              grant_kb_d;
  logic              grant_host_d;
  logic              host_fire;
  logic [31:0]       idx_w;
  logic              in_range;
  logic              is_toggle;
  logic [NUM_SW-1:0] sel_mask;

  assign host_fire    = host_valid_i & ~host_pend_q;
  assign host_ready_o = ~host_pend_q;
  assign switches_o   = sw_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_code_o   = cmd_code_q;
  assign busy_o       = (state_q != S_IDLE);

  // With both slots full, last_host_q picks the source that was not served last.
  always_comb begin
    grant_kb_d   = 1'b0;
    grant_host_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (kb_pend_q && host_pend_q) begin
        grant_kb_d   = last_host_q;
        grant_host_d = ~last_host_q;
      end else begin
        grant_kb_d   = kb_pend_q;
        grant_host_d = host_pend_q;
      end
    end
  end

  always_comb begin
    idx_w     = {27'd0, work_idx_q};
    in_range  = (idx_w < NUM_SW);
    is_toggle = (idx_w < SWITCHES_ST_COUNT) || (idx_w == AUX1_INDEX) || (idx_w == AUX2_INDEX);
    sel_mask  = in_range ? (NUM_SW'(1) << work_idx_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kb_pend_q   <= 1'b0;
      kb_idx_q    <= '0;
      kb_act_q    <= '0;
      host_pend_q <= 1'b0;
      host_idx_q  <= '0;
      host_act_q  <= '0;
      last_host_q <= 1'b1;
      work_idx_q  <= '0;
      work_act_q  <= '0;
      sw_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      // A reload in the grant cycle keeps the slot full with the newer entry.
      if (kb_valid_i) begin
        kb_pend_q <= 1'b1;
        kb_idx_q  <= kb_index_i;
        kb_act_q  <= kb_action_i;
      end else if (grant_kb_d) begin
        kb_pend_q <= 1'b0;
      end

      if (host_fire) begin
        host_pend_q <= 1'b1;
        host_idx_q  <= host_index_i;
        host_act_q  <= host_action_i;
      end else if (grant_host_d) begin
        host_pend_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_kb_d) begin
            work_idx_q  <= kb_idx_q;
            work_act_q  <= kb_act_q;
            last_host_q <= 1'b0;
            state_q     <= S_APPLY;
          end else if (grant_host_d) begin
            work_idx_q  <= host_idx_q;
            work_act_q  <= host_act_q;
            last_host_q <= 1'b1;
            state_q     <= S_APPLY;
          end
        end

        S_APPLY: begin
          state_q <= S_IDLE;
          if (in_range && (work_act_q != ACT_MOVE)) begin
            if (work_act_q == ACT_CLEAR) begin
              sw_q <= sw_q & ~sel_mask;
            end else if (is_toggle) begin
              if (work_act_q == ACT_UP) begin
                sw_q <= sw_q | sel_mask;
              end
            end else begin
              sw_q        <= sw_q | sel_mask;
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= {work_idx_q, (work_act_q == ACT_DOWN)};
              state_q     <= S_CMD;
            end
          end
        end

        S_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= CNT_W'(HOLD_CYCLES - 1);
            state_q     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_RELEASE: begin
          sw_q    <= sw_q & ~sel_mask;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_switch_ctrl.sv
// Bench for panel_switch_ctrl: event-timeline model checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_panel_switch_ctrl;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        kb_valid;
  logic [4:0]  kb_index;
  logic [1:0]  kb_action;
  logic        host_valid;
  logic [4:0]  host_index;
  logic [1:0]  host_action;
  logic        host_ready;
  logic [24:0] switches;
  logic        cmd_valid;
  logic [5:0]  cmd_code;
  logic        cmd_ready;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  panel_switch_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .kb_valid_i(kb_valid), .kb_index_i(kb_index), .kb_action_i(kb_action),
    .host_valid_i(host_valid), .host_index_i(host_index), .host_action_i(host_action),
    .host_ready_o(host_ready), .switches_o(switches),
    .cmd_valid_o(cmd_valid), .cmd_code_o(cmd_code), .cmd_ready_i(cmd_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each granted request is scheduled as events on an edge timeline
  // (apply edge, command handshake edge, release edge, next-free edge).
  int          cyc = 0;
  bit          m_kb_p, m_host_p, m_last_host;
  logic [4:0]  m_kb_i, m_host_i, m_op_i;
  logic [1:0]  m_kb_a, m_host_a, m_op_a;
  logic [24:0] m_sw;
  bit          m_cmd;
  logic [5:0]  m_code;
  int          m_free_at, m_apply_at, m_release_at;
  bit          gk, gh, hf, ign, tog, mom_set;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_kb_p = 0; m_host_p = 0; m_last_host = 1;
      m_sw = '0; m_cmd = 0; m_code = '0;
      m_free_at = 0; m_apply_at = -1; m_release_at = -1;
    end else begin
      gk = 0; gh = 0;
      hf = host_valid && !m_host_p;
      if (m_cmd && cmd_ready) begin
        m_cmd = 0;
        m_release_at = cyc + HOLD + 1;
        m_free_at    = cyc + HOLD + 2;
      end
      if (cyc == m_release_at) m_sw[m_op_i] = 1'b0;
      if (cyc == m_apply_at) begin
        ign = (m_op_a == 3) || (m_op_i >= 25);
        tog = (m_op_i < 18) || (m_op_i == 23) || (m_op_i == 24);
        if (!ign) begin
          if (m_op_a == 0) m_sw[m_op_i] = 1'b0;
          else if (tog) begin
            if (m_op_a == 1) m_sw[m_op_i] = 1'b1;
          end else begin
            m_sw[m_op_i] = 1'b1;
            m_cmd  = 1;
            m_code = {m_op_i, (m_op_a == 2)};
          end
        end
      end
      if (cyc >= m_free_at && (m_kb_p || m_host_p)) begin
        if (m_kb_p && m_host_p) gk = m_last_host;
        else gk = m_kb_p;
        gh = !gk;
        m_op_i = gk ? m_kb_i : m_host_i;
        m_op_a = gk ? m_kb_a : m_host_a;
        m_last_host = gh;
        m_apply_at = cyc + 1;
        ign = (m_op_a == 3) || (m_op_i >= 25);
        tog = (m_op_i < 18) || (m_op_i == 23) || (m_op_i == 24);
        mom_set = !ign && !tog && (m_op_a != 0);
        m_free_at = mom_set ? 1000000000 : cyc + 2;
      end
      if (kb_valid) begin m_kb_p = 1; m_kb_i = kb_index; m_kb_a = kb_action; end
      else if (gk) m_kb_p = 0;
      if (hf) begin m_host_p = 1; m_host_i = host_index; m_host_a = host_action; end
      else if (gh) m_host_p = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_switches", 32'(switches), 32'(m_sw));
      chk("model_cmd_valid", 32'(cmd_valid), 32'(m_cmd));
      chk("model_cmd_code", 32'(cmd_code), 32'(m_code));
      chk("model_busy", 32'(busy), 32'(m_free_at > cyc + 1));
      chk("model_host_ready", 32'(host_ready), 32'(!m_host_p));
    end
  end

  task automatic kb(input logic [4:0] i, input logic [1:0] a);
    kb_valid = 1; kb_index = i; kb_action = a;
    @(negedge clk);
    kb_valid = 0;
  endtask

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1; kb_valid = 0; kb_index = '0; kb_action = '0;
    host_valid = 0; host_index = '0; host_action = '0; cmd_ready = 0;
    nwait(3);
    reset = 0;
    chk_en = 1;
    chk("rst_switches", 32'(switches), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_host_ready", 32'(host_ready), 1);

    // toggle latency
    kb(5'd3, 2'd1);
    chk("t1_lat_c1", 32'(switches[3]), 0);
    nwait(1); chk("t1_lat_c2", 32'(switches[3]), 0);
    nwait(1); chk("t1_set", 32'(switches[3]), 1);
    nwait(2);
    kb(5'd3, 2'd0);
    nwait(2); chk("t1_clear", 32'(switches[3]), 0);

    // host momentary, immediate cmd_ready
    cmd_ready = 1;
    host_valid = 1; host_index = 5'd20; host_action = 2'd2;
    nwait(1); host_valid = 0;
    chk("t2_host_ready_low", 32'(host_ready), 0);
    nwait(2);
    chk("t2_cmd_valid", 32'(cmd_valid), 1);
    chk("t2_cmd_code", 32'(cmd_code), 32'h29);
    chk("t2_sw20_set", 32'(switches[20]), 1);
    nwait(1); chk("t2_cmd_drop", 32'(cmd_valid), 0);
    nwait(4); chk("t2_sw20_held", 32'(switches[20]), 1);
    nwait(1);
    chk("t2_sw20_rel", 32'(switches[20]), 0);
    chk("t2_busy_drop", 32'(busy), 0);

    // contention, two rounds
    nwait(2);
    for (int r = 0; r < 2; r++) begin
      kb_valid = 1; kb_index = 5'd1; kb_action = (r == 0) ? 2'd1 : 2'd0;
      host_valid = 1; host_index = 5'd2; host_action = (r == 0) ? 2'd1 : 2'd0;
      nwait(1); kb_valid = 0; host_valid = 0;
      chk("t3_host_ready_low", 32'(host_ready), 0);
      nwait(2);
      chk("t3_kb_first", 32'(switches[1]), (r == 0) ? 1 : 0);
      chk("t3_host_wait", 32'(switches[2]), (r == 0) ? 0 : 1);
      chk("t3_host_pending", 32'(host_ready), 0);
      nwait(1); chk("t3_host_ready_back", 32'(host_ready), 1);
      nwait(1); chk("t3_host_second", 32'(switches[2]), (r == 0) ? 1 : 0);
      nwait(2);
    end

    // cmd_ready held low, kb overwrite while busy
    cmd_ready = 0;
    kb(5'd19, 2'd1);
    nwait(2);
    chk("t4_cmd_valid", 32'(cmd_valid), 1);
    chk("t4_cmd_code", 32'(cmd_code), 32'h26);
    for (int i = 0; i < 10; i++) begin
      kb_valid = (i == 2) || (i == 5);
      kb_index = (i == 2) ? 5'd5 : 5'd6;
      kb_action = 2'd1;
      nwait(1);
    end
    kb_valid = 0;
    chk("t4_cmd_valid_held", 32'(cmd_valid), 1);
    chk("t4_cmd_code_held", 32'(cmd_code), 32'h26);
    cmd_ready = 1;
    nwait(20);
    chk("t4_sw19_rel", 32'(switches[19]), 0);
    chk("t4_first_dropped", 32'(switches[5]), 0);
    chk("t4_second_applied", 32'(switches[6]), 1);

    // AUX toggle and ignored requests
    kb(5'd23, 2'd1); nwait(4);
    kb(5'd23, 2'd2); nwait(4);
    kb(5'd30, 2'd1); nwait(4);
    kb(5'd4, 2'd3);  nwait(4);
    chk("t5_aux_set", 32'(switches[23]), 1);
    chk("t5_move_ignored", 32'(switches[4]), 0);
    chk("t5_no_cmd", 32'(cmd_valid), 0);
    chk("t5_switch_word", 32'(switches), 32'h0800040);

    // reset mid-HOLD with host pending
    kb(5'd21, 2'd1);
    nwait(4);
    host_valid = 1; host_index = 5'd0; host_action = 2'd1;
    nwait(1); host_valid = 0;
    chk("t6_in_hold", 32'(busy), 1);
    chk("t6_host_ready_low", 32'(host_ready), 0);
    reset = 1;
    nwait(1);
    reset = 0;
    chk("t6_switches", 32'(switches), 0);
    chk("t6_cmd_valid", 32'(cmd_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_host_ready", 32'(host_ready), 1);
    nwait(10);
    chk("t6_stays_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
